// File: rtl/uart_rx_fifo_if.sv
// Receiver-side bundle for uart_rx_fifo: serial line in, show-ahead FIFO head out.
// The receiver uses the slave modport; the consumer/line driver uses master.
interface uart_rx_fifo_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 i_RX_Serial;
  logic                 i_RX_Ready;
  logic                 i_Clr_Err;
  logic                 o_RX_Valid;
  logic [DATA_BITS-1:0] o_RX_Byte;
  logic                 o_Parity_Err;
  logic                 o_Frame_Err;
  logic                 o_Break;
  logic                 o_Overrun;

  modport slave (
    input  i_RX_Serial, i_RX_Ready, i_Clr_Err,
    output o_RX_Valid, o_RX_Byte, o_Parity_Err, o_Frame_Err, o_Break, o_Overrun
  );

  modport master (
    output i_RX_Serial, i_RX_Ready, i_Clr_Err,
    input  o_RX_Valid, o_RX_Byte, o_Parity_Err, o_Frame_Err, o_Break, o_Overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable frame format, 3-sample majority vote and a
// show-ahead receive FIFO carrying per-frame break/frame/parity error flags.
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input logic         clk,
  input logic         rst,
  uart_rx_fifo_if.slave bus
);
  localparam int unsigned CW  = $clog2(CLKS_PER_BIT);
  localparam int unsigned MID = (CLKS_PER_BIT - 1) / 2;
  localparam int unsigned EW  = DATA_BITS + 3;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] CntLast = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CntM1   = CW'(MID - 1);
  localparam logic [CW-1:0] CntMid  = CW'(MID);
  localparam logic [CW-1:0] CntP1   = CW'(MID + 1);
  localparam logic [3:0]    DataLast = 4'(DATA_BITS - 1);
  localparam logic [3:0]    StopLast = 4'(STOP_BITS - 1);
  localparam logic [AW:0]   FullCnt  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 s0_q, s0_d, s1_q, s1_d;
  logic                 par_q, par_d;
  logic                 ferr_q, ferr_d;
  logic                 stop0_q, stop0_d;
  logic                 rx_s1_q, rx_s2_q, rx_prev_q;

  logic                 rx, vote, at_end, at_dec;
  logic                 push, stop0_now, brk, fe, pe;
  logic [EW-1:0]        push_entry;

  // Synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= bus.i_RX_Serial;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  assign rx     = rx_s2_q;
  assign vote   = (s0_q & s1_q) | (s0_q & rx) | (s1_q & rx);
  assign at_end = (cnt_q == CntLast);
  assign at_dec = (cnt_q == CntP1);

  assign stop0_now = (bit_q == 4'd0) ? ~vote : stop0_q;
  assign brk = (shift_q == '0) && ((PARITY == 0) || !par_q) && stop0_now;
  assign fe  = ferr_q | ~vote | brk;
  always_comb begin
    pe = 1'b0;
    if (PARITY == 1)      pe = ~(^shift_q ^ par_q);
    else if (PARITY == 2) pe = ^shift_q ^ par_q;
  end
  assign push_entry = {brk, fe, pe, shift_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    par_d   = par_q;
    ferr_d  = ferr_q;
    stop0_d = stop0_q;
    push    = 1'b0;

    if (state_q != StIdle) begin
      cnt_d = at_end ? '0 : cnt_q + 1'b1;
      if (cnt_q == CntM1)  s0_d = rx;
      if (cnt_q == CntMid) s1_d = rx;
    end

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (rx_prev_q && !rx) begin
          state_d = StStart;
          bit_d   = '0;
          par_d   = 1'b0;
          ferr_d  = 1'b0;
          stop0_d = 1'b0;
        end
      end
      StStart: begin
        if (at_dec && vote) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (at_end) begin
          state_d = StData;
        end
      end
      StData: begin
        if (at_dec) shift_d = {vote, shift_q[DATA_BITS-1:1]};
        if (at_end) begin
          if (bit_q == DataLast) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? StParity : StStop;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (at_dec) par_d = vote;
        if (at_end) state_d = StStop;
      end
      StStop: begin
        if (at_dec) begin
          if (bit_q == 4'd0) stop0_d = ~vote;
          if (!vote)         ferr_d  = 1'b1;
          // Push at mid-stop so a start edge right after the stop bit is caught.
          if (bit_q == StopLast) begin
            push    = 1'b1;
            state_d = StIdle;
            cnt_d   = '0;
          end
        end else if (at_end) begin
          bit_d = bit_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      s0_q    <= 1'b1;
      s1_q    <= 1'b1;
      par_q   <= 1'b0;
      ferr_q  <= 1'b0;
      stop0_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      par_q   <= par_d;
      ferr_q  <= ferr_d;
      stop0_q <= stop0_d;
    end
  end

  // Show-ahead FIFO.
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          overrun_q;
  logic          valid, full, pop, accept;
  logic [EW-1:0] head;

  assign valid  = (count_q != '0);
  assign full   = (count_q == FullCnt);
  assign pop    = valid & bus.i_RX_Ready;
  assign accept = push & (~full | pop);
  assign head   = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW + 1)'(accept) - (AW + 1)'(pop);
      if (push && full && !pop) overrun_q <= 1'b1;
      else if (bus.i_Clr_Err)   overrun_q <= 1'b0;
    end
  end

  assign bus.o_RX_Valid   = valid;
  assign bus.o_RX_Byte    = valid ? head[DATA_BITS-1:0] : '0;
  assign bus.o_Parity_Err = valid & head[DATA_BITS];
  assign bus.o_Frame_Err  = valid & head[DATA_BITS+1];
  assign bus.o_Break      = valid & head[DATA_BITS+2];
  assign bus.o_Overrun    = overrun_q;
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with configurable frame format (5–9 data bits, optional odd/even parity, 1 or 2 stop bits), 3-sample majority-vote bit detection, per-frame error reporting and a small show-ahead receive FIFO with valid/ready pop. It replaces the single-format receiver in the serial path between the board UART pin and the command/data consumers. It also removes the need for consumers to catch a one-cycle data-valid pulse.

## Interface
- CLKS_PER_BIT, 217, clocks per bit period (clk freq / baud); legal ≥ 8
- DATA_BITS, 8, data bits per frame; legal 5..9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, legal 1 or 2
- FIFO_DEPTH, 4, receive FIFO entries; power of two, ≥ 2
- clk  input  1  system clock; all logic on posedge
- rst  input  1  synchronous, active-high reset
- i_RX_Serial  input  1  asynchronous serial line, idle high
- i_RX_Ready  input  1  consumer pops head entry when o_RX_Valid=1
- i_Clr_Err  input  1  clears sticky o_Overrun
- o_RX_Valid  output  1  FIFO not empty; head entry presented
- o_RX_Byte  output  DATA_BITS  head entry data, LSB = first received bit
- o_Parity_Err  output  1  head entry parity mismatch (always 0 when PARITY=0)
- o_Frame_Err  output  1  head entry had a stop bit sampled low
- o_Break  output  1  head entry is a break frame
- o_Overrun  output  1  sticky: a frame was dropped on a full FIFO

## Operation
- i_RX_Serial passes through a 2-flop synchroniser (reset value 1), then a 1-flop delayed copy for edge detection.
- Bit counter is $clog2(CLKS_PER_BIT) bits wide and runs 0..CLKS_PER_BIT-1 per bit period, wrapping to 0. MID = (CLKS_PER_BIT-1)/2.
- Majority vote: sample at counts MID-1, MID, MID+1. The bit value is the majority of the 3 samples and is decided at count MID+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: on a synchronised falling edge (prev=1, now=0), go to START with count=0. A line that is held low never retriggers; a high level must be seen first.
- START: if the voted start bit is 1 at MID+1, it is a false start and the FSM returns to IDLE. Otherwise the period completes to count CLKS_PER_BIT-1, then goes to DATA.
- DATA: DATA_BITS periods, one bit decided per period, shifted in LSB first. After the last period, go to PARITY if PARITY≠0, else STOP.
- PARITY: one period. Error when odd mode gives an even count of ones over data+parity, or even mode gives an odd count.
- STOP: STOP_BITS periods. Any stop bit voted 0 sets frame error.
- At MID+1 of the final stop bit, the frame is pushed to the FIFO and the FSM returns directly to IDLE. This lets a start edge immediately following the stop bit be caught.
- Break = all data bits 0, parity bit (if present) 0, and first stop bit 0. Break also sets frame error.
- FIFO entry = {break, frame_err, parity_err, data}.
- Push when full: the entry is dropped, FIFO contents are unchanged, and o_Overrun is set.
- Push and pop in the same cycle when full: the pop takes effect first and the push is accepted; count is unchanged.
- Push and pop in the same cycle when empty: the push is accepted and there is no pop.
- i_RX_Ready while o_RX_Valid=0 is ignored.
- o_Overrun stays 1 until i_Clr_Err=1. If an overrun and i_Clr_Err occur in the same cycle, set wins.
- o_RX_Byte, o_Parity_Err, o_Frame_Err and o_Break are driven 0 whenever o_RX_Valid=0.

## Timing
- Reset: FSM=IDLE, counters 0, FIFO empty, synchroniser flops 1. All outputs are 0.
- Reset mid-frame aborts the frame with no push. A new frame requires a fresh falling edge after reset.
- Input latency: 3 clk from the line changing to the edge being detected (2 synchroniser flops + 1 edge flop).
- Push occurs at MID+1 of the final stop bit. o_RX_Valid rises on the next clk edge when the FIFO was empty.
- Pop: the head advances on the clk edge where o_RX_Valid & i_RX_Ready. The next entry, or o_RX_Valid=0, is visible the following cycle. Consumers may pop every cycle.
- Tolerated baud mismatch is about ±(MID-1)/(CLKS_PER_BIT·frame bits).

## Test plan
- CLKS_PER_BIT=16, 8N1, send 0x55 then 0xA3 back-to-back -> two entries 0x55, 0xA3, all flags 0, o_RX_Valid high until two pops.
- PARITY=2, send 0x07 with parity bit 0 (wrong) -> entry 0x07, o_Parity_Err=1. Resend with parity bit 1 -> o_Parity_Err=0.
- 8N1, send 0x3C with stop bit held low for one bit time, then line high -> entry 0x3C, o_Frame_Err=1, o_Break=0.
- Line low for 12 bit times, then high, then 0x11 -> entry 0x00 with o_Break=1 and o_Frame_Err=1, followed by exactly one entry 0x11.
- 3-clk low glitch, and separately a single-sample noise pulse inside a data bit -> glitch produces no entry; noisy frame decodes correctly.
- FIFO_DEPTH=4, five frames with no pops -> first four retained, fifth dropped, o_Overrun=1. Pop in the same cycle as the fifth push instead -> all five accepted. i_Clr_Err clears o_Overrun. rst asserted mid-frame -> no entry, all outputs 0.
